// File: rtl/alu_pkg.sv
// Shared constants for the ALU result collector: unit tags, frame header base
// and serializer state encodings.
package alu_pkg;

  localparam logic [1:0] TAG_ARITH = 2'b00;
  localparam logic [1:0] TAG_LOGIC = 2'b01;
  localparam logic [1:0] TAG_CMP   = 2'b10;
  localparam logic [1:0] TAG_SHIFT = 2'b11;

  localparam logic [7:0] HDR_BASE = 8'hA0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  function automatic logic [7:0] hdr_byte(input logic [1:0] tag);
    return HDR_BASE | {6'b0, tag};
  endfunction

endpackage

// File: rtl/alu_result_tx_if.sv
// ALU result inputs plus the byte-stream handshake toward the transmit path.
// master = result producers / byte consumer, slave = the collector.
interface alu_result_tx_if #(
  parameter int width = 16
);
  logic [width-1:0] Arith_OUT;
  logic             Arith_Flag;
  logic [width-1:0] Logic_OUT;
  logic             Logic_Flag;
  logic [width-1:0] CMP_OUT;
  logic             CMP_Flag;
  logic [width-1:0] Shift_OUT;
  logic             Shift_Flag;
  logic             TX_READY;
  logic [7:0]       TX_DATA;
  logic             TX_VALID;
  logic             Busy;
  logic             Overflow_Flag;
  logic             Conflict_Flag;

  modport master (
    output Arith_OUT, Arith_Flag, Logic_OUT, Logic_Flag,
    output CMP_OUT, CMP_Flag, Shift_OUT, Shift_Flag, TX_READY,
    input  TX_DATA, TX_VALID, Busy, Overflow_Flag, Conflict_Flag
  );

  modport slave (
    input  Arith_OUT, Arith_Flag, Logic_OUT, Logic_Flag,
    input  CMP_OUT, CMP_Flag, Shift_OUT, Shift_Flag, TX_READY,
    output TX_DATA, TX_VALID, Busy, Overflow_Flag, Conflict_Flag
  );
endinterface

// File: rtl/alu_result_fifo.sv
// Synchronous FIFO with full/empty/count. A push while full is accepted only
// when a pop happens in the same cycle; the head is read combinationally.
module alu_result_fifo #(
  parameter int DW    = 18,
  parameter int Depth = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [DW-1:0]              wdata_i,
  output logic [DW-1:0]              rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth):0]     count_o
);
  localparam int AW = $clog2(Depth);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(Depth);

  logic [DW-1:0] mem_q [Depth];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset so it maps onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/alu_result_tx.sv
// Collects tagged ALU unit results into a FIFO and serializes each one as a
// header byte plus little-endian data bytes over a valid/ready byte stream.
module alu_result_tx
  import alu_pkg::*;
#(
  parameter int width = 16,
  parameter int Depth = 4
) (
  input logic            CLK,
  input logic            RST,
  alu_result_tx_if.slave bus
);
  localparam int NB   = width / 8;
  localparam int IDXW = (NB > 1) ? $clog2(NB) : 1;
  localparam int DW   = width + 2;
  localparam int CW   = $clog2(Depth) + 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NB - 1);

  logic             cap_valid;
  logic [1:0]       cap_tag;
  logic [width-1:0] cap_data;
  logic [2:0]       n_flags;
  logic             multi_flag;

  logic          fifo_pop, fifo_full, fifo_empty;
  logic [DW-1:0] fifo_rdata;
  logic [CW-1:0] fifo_count;

  state_e          state_q, state_d;
  logic [IDXW-1:0] byte_idx_q, byte_idx_d, byte_idx_nxt;
  logic [DW-1:0]   hold_q, hold_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_valid_q, tx_valid_d;
  logic            overflow_q, conflict_q;
  logic [7:0]      hold_bytes [NB];

  always_comb begin
    cap_valid = 1'b1;
    cap_tag   = TAG_ARITH;
    cap_data  = bus.Arith_OUT;
    if (bus.Arith_Flag) begin
      cap_tag  = TAG_ARITH;
      cap_data = bus.Arith_OUT;
    end else if (bus.Logic_Flag) begin
      cap_tag  = TAG_LOGIC;
      cap_data = bus.Logic_OUT;
    end else if (bus.CMP_Flag) begin
      cap_tag  = TAG_CMP;
      cap_data = bus.CMP_OUT;
    end else if (bus.Shift_Flag) begin
      cap_tag  = TAG_SHIFT;
      cap_data = bus.Shift_OUT;
    end else begin
      cap_valid = 1'b0;
    end
  end

  assign n_flags = 3'(bus.Arith_Flag) + 3'(bus.Logic_Flag)
                 + 3'(bus.CMP_Flag) + 3'(bus.Shift_Flag);
  assign multi_flag = (n_flags > 3'd1);

  alu_result_fifo #(
    .DW    (DW),
    .Depth (Depth)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (cap_valid),
    .pop_i   (fifo_pop),
    .wdata_i ({cap_tag, cap_data}),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_bytes
      assign hold_bytes[gi] = hold_q[8*gi +: 8];
    end
  endgenerate

  assign byte_idx_nxt = byte_idx_q + 1'b1;

  // Output byte/valid are computed one step ahead so they come straight from flops.
  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    hold_d     = hold_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    fifo_pop   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          hold_d     = fifo_rdata;
          state_d    = ST_HDR;
          tx_valid_d = 1'b1;
          tx_data_d  = hdr_byte(fifo_rdata[width +: 2]);
        end
      end
      ST_HDR: begin
        if (bus.TX_READY) begin
          state_d    = ST_DATA;
          byte_idx_d = '0;
          tx_data_d  = hold_bytes[0];
        end
      end
      ST_DATA: begin
        if (bus.TX_READY) begin
          if (byte_idx_q == LAST_IDX) begin
            state_d    = ST_IDLE;
            byte_idx_d = '0;
            tx_valid_d = 1'b0;
            tx_data_d  = '0;
          end else begin
            byte_idx_d = byte_idx_nxt;
            tx_data_d  = hold_bytes[byte_idx_nxt];
          end
        end
      end
      default: begin
        state_d    = ST_IDLE;
        tx_valid_d = 1'b0;
        tx_data_d  = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      byte_idx_q <= '0;
      hold_q     <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      overflow_q <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      hold_q     <= hold_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      overflow_q <= overflow_q | (cap_valid && fifo_full && !fifo_pop);
      conflict_q <= conflict_q | multi_flag;
    end
  end

  assign bus.TX_DATA       = tx_data_q;
  assign bus.TX_VALID      = tx_valid_q;
  assign bus.Busy          = (state_q != ST_IDLE) || (fifo_count != '0);
  assign bus.Overflow_Flag = overflow_q;
  assign bus.Conflict_Flag = conflict_q;

endmodule

// File: tb/tb_alu_result_tx.sv
// Directed bench for alu_result_tx: drives result pulses, collects transferred
// bytes and compares against hand-computed frames.
module tb_alu_result_tx;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [7:0] rx_q [$];

  alu_result_tx_if #(.width(16)) bus ();

  alu_result_tx #(.width(16), .Depth(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  always #5 CLK = ~CLK;

  // Inputs change just after posedge, so the negedge sees a settled handshake.
  always @(negedge CLK) begin
    if (bus.TX_VALID && bus.TX_READY) begin
      rx_q.push_back(bus.TX_DATA);
      $display("tx byte %02h at %0t", bus.TX_DATA, $time);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    bus.Arith_OUT = '0; bus.Arith_Flag = 1'b0;
    bus.Logic_OUT = '0; bus.Logic_Flag = 1'b0;
    bus.CMP_OUT   = '0; bus.CMP_Flag   = 1'b0;
    bus.Shift_OUT = '0; bus.Shift_Flag = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (bus.TX_VALID !== 1'b0 || bus.TX_DATA !== 8'h00 || bus.Busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b data=%02h busy=%b, required 0/00/0",
               bus.TX_VALID, bus.TX_DATA, bus.Busy);
    end
    checks++;
    if (bus.Overflow_Flag !== 1'b0 || bus.Conflict_Flag !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: ovf=%b conf=%b, required 0/0", bus.Overflow_Flag, bus.Conflict_Flag);
    end
  endtask

  task automatic test_single();
    logic [7:0] exp [3] = '{8'hA3, 8'h34, 8'h12};
    rx_q.delete();
    bus.TX_READY = 1'b1;
    bus.Shift_OUT = 16'h1234; bus.Shift_Flag = 1'b1;
    tick();
    clear_inputs();
    checks++;
    if (bus.TX_VALID !== 1'b0 || bus.Busy !== 1'b1) begin
      errors++;
      $display("FAIL single_n1: valid=%b busy=%b, required 0/1", bus.TX_VALID, bus.Busy);
    end
    tick();
    checks++;
    if (bus.TX_VALID !== 1'b1 || bus.TX_DATA !== 8'hA3) begin
      errors++;
      $display("FAIL single_hdr_latency: valid=%b data=%02h, required 1/a3", bus.TX_VALID, bus.TX_DATA);
    end
    tick();
    tick();
    checks++;
    if (bus.Busy !== 1'b1 || bus.TX_DATA !== 8'h12) begin
      errors++;
      $display("FAIL single_last: busy=%b data=%02h, required 1/12", bus.Busy, bus.TX_DATA);
    end
    tick();
    checks++;
    if (bus.Busy !== 1'b0 || bus.TX_VALID !== 1'b0) begin
      errors++;
      $display("FAIL single_done: busy=%b valid=%b, required 0/0", bus.Busy, bus.TX_VALID);
    end
    checks++;
    if (rx_q.size() != 3) begin
      errors++;
      $display("FAIL single_len: got %0d bytes, required 3", rx_q.size());
    end
    for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp[i]) begin
        errors++;
        $display("FAIL single_byte%0d: got %02h, required %02h", i, rx_q[i], exp[i]);
      end
    end
    checks++;
    if (bus.Conflict_Flag !== 1'b0) begin
      errors++;
      $display("FAIL single_noconflict: conf=%b, required 0", bus.Conflict_Flag);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp [3] = '{8'hA0, 8'hEF, 8'hBE};
    int bad = 0;
    rx_q.delete();
    bus.TX_READY = 1'b0;
    bus.Arith_OUT = 16'hBEEF; bus.Arith_Flag = 1'b1;
    tick();
    clear_inputs();
    tick();
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (bus.TX_VALID !== 1'b1 || bus.TX_DATA !== 8'hA0) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%b data=%02h, required 1/a0", c, bus.TX_VALID, bus.TX_DATA);
      end
      tick();
    end
    bus.TX_READY = 1'b1;
    for (int k = 0; k < 20 && bus.Busy; k++) tick();
    checks++;
    if (bus.Busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_timeout: busy=%b, required 0", bus.Busy);
    end
    checks++;
    if (rx_q.size() != 3) begin
      errors++;
      $display("FAIL bp_len: got %0d bytes, required 3", rx_q.size());
    end
    for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
      if (rx_q[i] !== exp[i]) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_bytes: %0d wrong bytes, required 0", bad);
    end
  endtask

  task automatic test_conflict();
    logic [7:0] exp [3] = '{8'hA1, 8'hFF, 8'h00};
    int bad = 0;
    rx_q.delete();
    bus.TX_READY = 1'b1;
    bus.Logic_OUT = 16'h00FF; bus.Logic_Flag = 1'b1;
    bus.CMP_OUT   = 16'h5555; bus.CMP_Flag   = 1'b1;
    tick();
    clear_inputs();
    for (int k = 0; k < 20 && bus.Busy; k++) tick();
    tick();
    checks++;
    if (rx_q.size() != 3) begin
      errors++;
      $display("FAIL conflict_len: got %0d bytes, required 3", rx_q.size());
    end
    for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
      if (rx_q[i] !== exp[i]) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL conflict_bytes: %0d wrong bytes, required 0", bad);
    end
    checks++;
    if (bus.Conflict_Flag !== 1'b1 || bus.Overflow_Flag !== 1'b0) begin
      errors++;
      $display("FAIL conflict_flags: conf=%b ovf=%b, required 1/0", bus.Conflict_Flag, bus.Overflow_Flag);
    end
  endtask

  task automatic test_overflow();
    int bad = 0;
    rx_q.delete();
    bus.TX_READY = 1'b0;
    for (int v = 1; v <= 6; v++) begin
      bus.Arith_OUT = 16'(v); bus.Arith_Flag = 1'b1;
      tick();
    end
    clear_inputs();
    checks++;
    if (bus.Overflow_Flag !== 1'b1) begin
      errors++;
      $display("FAIL overflow_flag: ovf=%b, required 1", bus.Overflow_Flag);
    end
    checks++;
    if (bus.TX_VALID !== 1'b1 || bus.TX_DATA !== 8'hA0) begin
      errors++;
      $display("FAIL overflow_hdr: valid=%b data=%02h, required 1/a0", bus.TX_VALID, bus.TX_DATA);
    end
    bus.TX_READY = 1'b1;
    for (int k = 0; k < 60 && bus.Busy; k++) tick();
    tick();
    checks++;
    if (rx_q.size() != 15) begin
      errors++;
      $display("FAIL overflow_len: got %0d bytes, required 15", rx_q.size());
    end
    for (int f = 0; f < 5 && 3*f+2 < rx_q.size(); f++) begin
      if (rx_q[3*f] !== 8'hA0 || rx_q[3*f+1] !== 8'(f+1) || rx_q[3*f+2] !== 8'h00) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL overflow_order: %0d wrong frames, required 0", bad);
    end
    checks++;
    if (bus.Conflict_Flag !== 1'b1 || bus.Overflow_Flag !== 1'b1) begin
      errors++;
      $display("FAIL sticky_flags: conf=%b ovf=%b, required 1/1", bus.Conflict_Flag, bus.Overflow_Flag);
    end
  endtask

  task automatic test_full_pop();
    logic [7:0] vals [6] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd9};
    int bad = 0;
    do_reset();
    rx_q.delete();
    bus.TX_READY = 1'b0;
    for (int v = 1; v <= 5; v++) begin
      bus.Arith_OUT = 16'(v); bus.Arith_Flag = 1'b1;
      tick();
    end
    clear_inputs();
    bus.TX_READY = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if (bus.TX_VALID !== 1'b0 || bus.Busy !== 1'b1) begin
      errors++;
      $display("FAIL fullpop_idle: valid=%b busy=%b, required 0/1", bus.TX_VALID, bus.Busy);
    end
    bus.Arith_OUT = 16'd9; bus.Arith_Flag = 1'b1;
    tick();
    clear_inputs();
    checks++;
    if (bus.Overflow_Flag !== 1'b0) begin
      errors++;
      $display("FAIL fullpop_noovf: ovf=%b, required 0", bus.Overflow_Flag);
    end
    checks++;
    if (dut.u_fifo.count_q !== 3'd4) begin
      errors++;
      $display("FAIL fullpop_count: count=%0d, required 4", dut.u_fifo.count_q);
    end
    for (int k = 0; k < 60 && bus.Busy; k++) tick();
    tick();
    checks++;
    if (rx_q.size() != 18) begin
      errors++;
      $display("FAIL fullpop_len: got %0d bytes, required 18", rx_q.size());
    end
    for (int f = 0; f < 6 && 3*f+2 < rx_q.size(); f++) begin
      if (rx_q[3*f] !== 8'hA0 || rx_q[3*f+1] !== vals[f] || rx_q[3*f+2] !== 8'h00) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL fullpop_order: %0d wrong frames, required 0", bad);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [12] = '{8'hA0, 8'h11, 8'h11, 8'hA1, 8'h22, 8'h22,
                             8'hA2, 8'h33, 8'h33, 8'hA3, 8'h44, 8'h44};
    int bad = 0;
    rx_q.delete();
    bus.TX_READY = 1'b1;
    bus.Arith_OUT = 16'h1111; bus.Arith_Flag = 1'b1;
    tick();
    clear_inputs();
    bus.Logic_OUT = 16'h2222; bus.Logic_Flag = 1'b1;
    tick();
    clear_inputs();
    bus.CMP_OUT = 16'h3333; bus.CMP_Flag = 1'b1;
    tick();
    clear_inputs();
    bus.Shift_OUT = 16'h4444; bus.Shift_Flag = 1'b1;
    tick();
    clear_inputs();
    repeat (12) tick();
    checks++;
    if (bus.Busy !== 1'b1 || bus.TX_VALID !== 1'b1 || bus.TX_DATA !== 8'h44) begin
      errors++;
      $display("FAIL b2b_last: busy=%b valid=%b data=%02h, required 1/1/44",
               bus.Busy, bus.TX_VALID, bus.TX_DATA);
    end
    tick();
    checks++;
    if (bus.Busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_throughput: busy=%b, required 0", bus.Busy);
    end
    checks++;
    if (rx_q.size() != 12) begin
      errors++;
      $display("FAIL b2b_len: got %0d bytes, required 12", rx_q.size());
    end
    for (int i = 0; i < 12 && i < rx_q.size(); i++) begin
      if (rx_q[i] !== exp[i]) bad++;
    end
    checks++;
    if (bad != 0 || bus.Overflow_Flag !== 1'b0 || bus.Conflict_Flag !== 1'b0) begin
      errors++;
      $display("FAIL b2b_bytes: %0d wrong bytes ovf=%b conf=%b, required 0/0/0",
               bad, bus.Overflow_Flag, bus.Conflict_Flag);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp [3] = '{8'hA3, 8'hFE, 8'hCA};
    int bad = 0;
    bus.TX_READY = 1'b1;
    bus.Arith_OUT = 16'h5A5A; bus.Arith_Flag = 1'b1;
    tick();
    clear_inputs();
    bus.Logic_OUT = 16'h1111; bus.Logic_Flag = 1'b1; bus.CMP_Flag = 1'b1;
    tick();
    clear_inputs();
    tick();
    checks++;
    if (bus.TX_DATA !== 8'h5A || bus.Conflict_Flag !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre: data=%02h conf=%b, required 5a/1", bus.TX_DATA, bus.Conflict_Flag);
    end
    RST = 1'b1;
    tick();
    checks++;
    if (bus.TX_VALID !== 1'b0 || bus.TX_DATA !== 8'h00 || bus.Busy !== 1'b0 ||
        bus.Overflow_Flag !== 1'b0 || bus.Conflict_Flag !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_clear: valid=%b data=%02h busy=%b ovf=%b conf=%b, required all 0",
               bus.TX_VALID, bus.TX_DATA, bus.Busy, bus.Overflow_Flag, bus.Conflict_Flag);
    end
    RST = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.TX_VALID !== 1'b0 || bus.Busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_discard: valid=%b busy=%b, required 0/0", bus.TX_VALID, bus.Busy);
    end
    rx_q.delete();
    bus.Shift_OUT = 16'hCAFE; bus.Shift_Flag = 1'b1;
    tick();
    clear_inputs();
    for (int k = 0; k < 20 && bus.Busy; k++) tick();
    tick();
    checks++;
    if (rx_q.size() != 3) begin
      errors++;
      $display("FAIL rstmid_len: got %0d bytes, required 3", rx_q.size());
    end
    for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
      if (rx_q[i] !== exp[i]) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rstmid_frame: %0d wrong bytes, required 0", bad);
    end
  endtask

  initial begin
    clear_inputs();
    bus.TX_READY = 1'b0;
    do_reset();
    test_reset();
    test_single();
    test_backpressure();
    test_conflict();
    test_overflow();
    test_full_pop();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_result_tx.md
# alu_result_tx

Downstream collector for the ALU's four registered execution units (arithmetic, logic, compare, shift). It captures each result qualified by its unit flag, tags it with the source unit, and buffers it in a small FIFO. It then serializes each result as a byte frame over a valid/ready handshake toward the byte-oriented transmit path, such as a UART TX. This decouples bursty single-cycle ALU results from a slow byte consumer.

## Interface
- `width`, 16, operand/result width of every unit; must be a multiple of 8 and at least 8.
- `Depth`, 4, FIFO entries; power of two, at least 2.
- `CLK` input 1: single clock, rising edge.
- `RST` input 1: synchronous, active-high reset.
- `Arith_OUT` input width: arithmetic unit result.
- `Arith_Flag` input 1: arithmetic result valid this cycle.
- `Logic_OUT` input width: logic unit result.
- `Logic_Flag` input 1: logic result valid.
- `CMP_OUT` input width: compare unit result.
- `CMP_Flag` input 1: compare result valid.
- `Shift_OUT` input width: shift unit result.
- `Shift_Flag` input 1: shift result valid.
- `TX_READY` input 1: consumer accepts `TX_DATA` this cycle.
- `TX_DATA` output 8: current frame byte.
- `TX_VALID` output 1: `TX_DATA` is valid.
- `Busy` output 1: FIFO non-empty or a frame is in flight.
- `Overflow_Flag` output 1: sticky; a result was dropped because the FIFO was full.
- `Conflict_Flag` output 1: sticky; more than one unit flag was high in the same cycle.

## Operation
- **Capture:** any unit flag high pushes one entry `{tag[1:0], result[width-1:0]}`.
- **Tags:** Arith=00, Logic=01, CMP=10, Shift=11.
- **Multiple flags:** if several flags are high, priority is Arith > Logic > CMP > Shift. Only the winner is stored, and `Conflict_Flag` sets.
- **Full FIFO:**
  - A push when full is dropped and `Overflow_Flag` sets.
  - Exception: if a pop occurs in the same cycle, the push is accepted and count stays `Depth`.
- **Frame format:** header byte `8'hA0 | tag`, then `width/8` data bytes, least-significant byte first. Frame length is `1 + width/8`; the default is 3 bytes.
- **FSM states:** IDLE, HDR, DATA.
  - IDLE: `TX_VALID`=0. If the FIFO is non-empty, pop the head into the hold register, go to HDR.
  - HDR: `TX_VALID`=1, `TX_DATA`=header. On `TX_READY`, go to DATA with `byte_idx`=0.
  - DATA: `TX_VALID`=1, `TX_DATA`=`hold[8*byte_idx +: 8]`. On `TX_READY`:
    - if `byte_idx` = `width/8-1`, go to IDLE;
    - otherwise increment `byte_idx`.
- **Handshake:** a byte transfers only when `TX_VALID` and `TX_READY` are both high. While `TX_READY`=0, `TX_DATA` and `TX_VALID` hold stable. `TX_VALID` never drops before a transfer.
- **Pointers:** read/write pointers wrap modulo `Depth`. Count ranges 0..`Depth`.
- **Sticky flags:** `Overflow_Flag` and `Conflict_Flag` clear only on `RST`.

## Timing
- **Reset (RST sampled high at an edge):**
  - FSM goes to IDLE; pointers, count and `byte_idx` clear to 0.
  - `TX_DATA`=0, `TX_VALID`=0, `Busy`=0, `Overflow_Flag`=0, `Conflict_Flag`=0.
  - Reset mid-frame aborts the frame and discards FIFO contents. There is no partial-frame completion.
- **Latency:** flag high in cycle n → FIFO written at end of n → IDLE pops in n+1 → `TX_VALID` with header in n+2.
- **Throughput:**
  - IDLE costs one bubble cycle between frames.
  - With `TX_READY` tied high, one frame takes `2 + width/8` cycles; the default is 4.
- **Simultaneous push and pop:** allowed every cycle. Count is unchanged.
- **Push into an empty FIFO while in IDLE:** the entry is not visible until the next cycle. There is no bypass.
- **`Busy`:** combinational from state and count; high from cycle n+1 until the last byte transfers with the FIFO empty.
- All outputs except `Busy` are registered.

## Structure
- **Shared `alu_pkg`:**
  - tag constants `TAG_ARITH`, `TAG_LOGIC`, `TAG_CMP`, `TAG_SHIFT`;
  - `HDR_BASE` = `8'hA0`;
  - FSM state encodings `ST_IDLE`, `ST_HDR`, `ST_DATA`.
- **Sub-module `alu_result_fifo`:** a synchronous FIFO with full/empty/count, parameterised on data width (`width+2`) and `Depth`.
- Top level keeps the priority capture, the sticky flags and the serializer FSM.

## Test plan
- **Single result:**
  - Stimulus: `Shift_OUT`=16'h1234 with `Shift_Flag`=1 for one cycle, `TX_READY`=1.
  - Response: bytes A3, 34, 12; `TX_VALID` rises 2 cycles after the flag; `Busy` falls after byte 12.
- **Backpressure:**
  - Stimulus: `Arith_OUT`=16'hBEEF, `TX_READY` low for 5 cycles during the header.
  - Response: `TX_DATA`=A0 held stable with `TX_VALID`=1, then A0, EF, BE.
- **Conflict:**
  - Stimulus: `Logic_Flag` and `CMP_Flag` high together, `Logic_OUT`=16'h00FF.
  - Response: only the frame A1, FF, 00 is sent; `Conflict_Flag`=1 and stays 1.
- **Overflow:**
  - Stimulus: `TX_READY`=0 with 6 consecutive `Arith_Flag` pulses, values 1..6.
  - Response: one entry sits in the hold register, 4 are queued and 1 is dropped; `Overflow_Flag`=1.
  - After releasing `TX_READY`, values 1..5 are sent in order.
- **Full with simultaneous pop:**
  - Stimulus: FIFO full and FSM in IDLE; a push arrives in the same cycle as the pop.
  - Response: the push is accepted, no overflow, count stays 4.
- **Reset mid-frame:**
  - Stimulus: assert `RST` after the header byte of a 3-byte frame.
  - Response: next cycle `TX_VALID`=0, all flags 0, FIFO empty; a new result afterwards sends a complete frame.
